pc_sequencer: RTL

Fetch-side controller for the RISC-V core. It owns the program counter and sequences the shared 32-bit PC adder between sequential increment (PC + 4) and redirect-target computation (base + offset). It issues instruction-memory requests with a hold-until-ack handshake and honours decode stalls. It squashes fetches that a branch or jump makes stale.

---
 rtl/pc_seq_pkg.sv | 29 ++
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_sequencer_adder.sv | 11 +
 rtl/pc_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
// Combinational definitions only; no latency, no backpressure.
package pc_seq_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] xlen_t;

   // Instruction fetch addresses are always word aligned.
   localparam xlen_t ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      SQUASH = 2'd2,
      STALL  = 2'd3
   } state_e;

   typedef struct packed {
      logic  vld;
      xlen_t base;
      xlen_t offset;
   } redir_t;

   function automatic xlen_t align_word(input xlen_t addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch bus between sequencer, instruction memory and decode.
// Wires only; imem_req is held until imem_ack, and stall backpressures the sequencer.
interface pc_sequencer_if;
   import pc_seq_pkg::*;

   logic  stall;
   logic  redirect_valid;
   xlen_t redirect_base;
   xlen_t redirect_offset;
   logic  imem_req;
   xlen_t imem_addr;
   logic  imem_ack;
   logic  instr_valid;
   xlen_t instr_pc;

   modport master (
      input  stall, redirect_valid, redirect_base, redirect_offset, imem_ack,
      output imem_req, imem_addr, instr_valid, instr_pc
   );

   modport slave (
      output stall, redirect_valid, redirect_base, redirect_offset, imem_ack,
      input  imem_req, imem_addr, instr_valid, instr_pc
   );

endinterface

// File: rtl/pc_sequencer_adder.sv
// Shared 32-bit adder used for both PC increment and redirect targets.
// Purely combinational, wraps modulo 2^32; no backpressure.
module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC and issues instruction fetches; instr_valid follows imem_ack by one cycle.
// imem_req holds until imem_ack; decode stall parks the sequencer with imem_req low.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] INSTR_BYTES  = 32'd4
) (
   input  logic           clk,
   input  logic           rst_n,
   pc_sequencer_if.master bus
);

   state_e state_q, state_d;
   xlen_t  pc_q, pc_d;
   xlen_t  redir_tgt_q, redir_tgt_d;
   logic   redir_pend_q, redir_pend_d;
   logic   instr_valid_q, instr_valid_d;
   xlen_t  instr_pc_q, instr_pc_d;

   redir_t redir;
   xlen_t  add_a, add_b, add_sum, target;
   logic   imem_req;

   assign redir = '{vld: bus.redirect_valid, base: bus.redirect_base, offset: bus.redirect_offset};

   // One adder serves both paths; a redirect always takes it over.
   always_comb begin
      add_a = pc_q;
      add_b = INSTR_BYTES;
      if (redir.vld) begin
         add_a = redir.base;
         add_b = redir.offset;
      end
   end

   adder u_adder (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum)
   );

   assign target = align_word(add_sum);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redir_tgt_d   = redir_tgt_q;
      redir_pend_d  = redir_pend_q;
      instr_valid_d = 1'b0;
      instr_pc_d    = instr_pc_q;
      imem_req      = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
            if (redir.vld) pc_d = target;
         end

         FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               if (redir.vld) begin
                  pc_d = target;
               end else begin
                  pc_d          = add_sum;
                  instr_valid_d = 1'b1;
                  instr_pc_d    = pc_q;
               end
               state_d = bus.stall ? STALL : FETCH;
            end else if (redir.vld) begin
               redir_tgt_d  = target;
               redir_pend_d = 1'b1;
               state_d      = SQUASH;
            end
         end

         SQUASH: begin
            // The stale request must still complete before the PC can move.
            imem_req = 1'b1;
            if (redir.vld) redir_tgt_d = target;
            if (bus.imem_ack) begin
               if (redir.vld)         pc_d = target;
               else if (redir_pend_q) pc_d = redir_tgt_q;
               redir_pend_d = 1'b0;
               state_d      = bus.stall ? STALL : FETCH;
            end
         end

         STALL: begin
            if (redir.vld) pc_d = target;
            if (!bus.stall) state_d = FETCH;
         end

         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VECTOR;
         redir_tgt_q   <= '0;
         redir_pend_q  <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redir_tgt_q   <= redir_tgt_d;
         redir_pend_q  <= redir_pend_d;
         instr_valid_q <= instr_valid_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   assign bus.imem_req    = imem_req;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_pc    = instr_pc_q;

endmodule
